// File: rtl/mp_add_pkg.sv
// Shared types, defaults and sizing helper for the multi-precision adder sequencer.
package mp_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned MP_W     = 64;
  localparam int unsigned MP_WORDS = 4;

  // A single-word operand still needs a 1-bit index register.
  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mp_add_word.sv
// W-bit combinational ripple-carry adder built from a chain of full-adder cells.
module mp_add_word
  import mp_add_pkg::*;
#(
  parameter int unsigned W = MP_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         c_in,
  output logic [W-1:0] z,
  output logic         c_out
);

  logic [W:0] w_c;

  assign w_c[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign z[i]       = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i + 1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign c_out = w_c[W];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision adder sequencer: one shared word adder, one word per cycle, LSW first.
// Optional subtract mode (A - B - borrow-in) is enabled by defining MP_ADD_SEQ_SUB_EN.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int unsigned WORDS = MP_WORDS,
  parameter int unsigned W     = MP_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WORDS*W-1:0] op_a,
  input  logic [WORDS*W-1:0] op_b,
  input  logic               cin,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic               sub,
`endif
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WORDS*W-1:0] result,
  output logic               cout,
  output logic               busy
);

  localparam int unsigned    IW       = idx_width(WORDS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(WORDS - 1);

  state_t             r_state;
  logic [WORDS*W-1:0] r_a;
  logic [WORDS*W-1:0] r_b;
  logic [WORDS*W-1:0] r_result;
  logic               r_carry;
  logic               r_cout;
  logic [IW-1:0]      r_idx;

  logic [W-1:0]       w_a_word;
  logic [W-1:0]       w_b_word;
  logic [W-1:0]       w_sum;
  logic               w_carry_out;
  logic               w_last;
  logic               w_carry_init;

  assign w_a_word = r_a[r_idx*W +: W];
  assign w_last   = (r_idx == LAST_IDX);

`ifdef MP_ADD_SEQ_SUB_EN
  logic r_sub;

  // Subtraction as A + ~B + ~borrow; cout=1 then means no borrow.
  assign w_b_word     = r_b[r_idx*W +: W] ^ {W{r_sub}};
  assign w_carry_init = cin ^ sub;
`else
  assign w_b_word     = r_b[r_idx*W +: W];
  assign w_carry_init = cin;
`endif

  mp_add_word #(
    .W(W)
  ) u_word (
    .x    (w_a_word),
    .y    (w_b_word),
    .c_in (r_carry),
    .z    (w_sum),
    .c_out(w_carry_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_carry <= w_carry_init;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_result[r_idx*W +: W] <= w_sum;
          r_carry                <= w_carry_out;
          // Index saturates at the top word so it never wraps.
          if (w_last) begin
            r_cout  <= w_carry_out;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MP_ADD_SEQ_SUB_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (r_state == IDLE && start_valid) begin
      r_sub <= sub;
    end
  end
`endif

  assign start_ready = (r_state == IDLE);
  assign res_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign result      = r_result;
  assign cout        = r_cout;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq: vector table, scoreboard queue and multi-cycle corner cases.
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 64;
  localparam int N     = WORDS * W;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] res;
    logic         cout;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic         cin;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] result;
  logic         cout;
  logic         busy;
`ifdef MP_ADD_SEQ_SUB_EN
  logic         sub_i = 1'b0;
`endif

  int           n_cmp    = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           last_acc = -100;
  int           last_hs  = -100;
  int           acc_gap  = 0;
  int           n_acc    = 0;
  logic         prev_rv  = 1'b0;
  logic [N:0]   sb_q[$];
  vec_t         tbl[6];

  always #5 clk = ~clk;

  mp_add_seq #(
    .WORDS(WORDS),
    .W    (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .cin        (cin),
`ifdef MP_ADD_SEQ_SUB_EN
    .sub        (sub_i),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .cout       (cout),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got no response, expected one within 50 cycles", name);
  endtask

  function automatic logic [N-1:0] rand256();
    logic [N-1:0] v;
    for (int k = 0; k < N / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  // Scoreboard / timing monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [N:0] exp;
    if (!rst_n) begin
      prev_rv = 1'b0;
    end else begin
      cyc++;
      if (res_valid && !prev_rv) check("latency", cyc - last_acc, WORDS + 1);
      if (start_valid && start_ready) begin
        acc_gap  = cyc - last_hs;
        last_acc = cyc;
        n_acc++;
      end
      if (res_valid && res_ready) begin
        last_hs = cyc;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: got result %h, expected no result", result);
        end else begin
          exp = sb_q.pop_front();
          check("sb_result", {1'b0, result}, {1'b0, exp[N-1:0]});
          check("sb_cout", cout, exp[N]);
        end
      end
      prev_rv = res_valid;
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                       input logic [N:0] exp);
    int n = 0;
    sb_q.push_back(exp);
    op_a = a;
    op_b = b;
    cin = c;
    start_valid = 1'b1;
    while (!start_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready) timeout("accept_timeout");
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!res_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!res_valid) timeout("result_timeout");
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("idle_after_hs", start_ready, 1);
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                       input logic [N:0] exp);
    issue(a, b, c, exp);
    wait_valid();
    handshake();
  endtask

  initial begin
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0]   exp;
    logic         rv_seen;
    int           base;
    int           n;

    rst_n = 1'b0;
    start_valid = 1'b0;
    res_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    cin = 1'b0;

    tbl[0] = '{a: '1, b: 256'd1, cin: 1'b0, res: '0, cout: 1'b1};
    tbl[1] = '{a: {192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, b: 256'd1, cin: 1'b0,
               res: {64'h0, 64'h0, 64'h1, 64'h0}, cout: 1'b0};
    tbl[2] = '{a: 256'd5, b: 256'd7, cin: 1'b1, res: 256'd13, cout: 1'b0};
    tbl[3] = '{a: '1, b: '1, cin: 1'b1, res: '1, cout: 1'b1};
    tbl[4] = '{a: {1'b1, 255'd0}, b: {1'b1, 255'd0}, cin: 1'b0, res: '0, cout: 1'b1};
    tbl[5] = '{a: {64'h0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0},
               b: {64'h0, 64'h8000_0000_0000_0000, 64'h1, 64'h0}, cin: 1'b1,
               res: {64'h1, 64'h1, 64'h0, 64'h1}, cout: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", {1'b0, result}, 0);
    check("rst_cout", cout, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].cout, tbl[i].res});
    end

    for (int i = 0; i < 3; i++) begin
      a = rand256();
      b = rand256();
      do_op(a, b, i[0], model(a, b, i[0]));
    end

    // Backpressure: hold DONE while new requests and operands churn on the inputs.
    a = rand256();
    b = rand256();
    exp = model(a, b, 1'b0);
    issue(a, b, 1'b0, exp);
    wait_valid();
    for (int k = 0; k < 10; k++) begin
      start_valid = 1'b1;
      op_a = rand256();
      op_b = rand256();
      cin = k[0];
      res_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_result", {1'b0, result}, {1'b0, exp[N-1:0]});
      check("bp_cout", cout, exp[N]);
      check("bp_start_ready", start_ready, 0);
      check("bp_res_valid", res_valid, 1);
    end
    a = rand256();
    b = rand256();
    op_a = a;
    op_b = b;
    cin = 1'b1;
    sb_q.push_back(model(a, b, 1'b1));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    check("bp_accept_busy", busy, 1);
    check("bp_accept_gap", acc_gap, 1);
    wait_valid();
    handshake();

    // Reset asserted on the second RUN cycle.
    op_a = rand256();
    op_b = rand256();
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start_ready", start_ready, 1);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result", {1'b0, result}, 0);
    check("mid_rst_cout", cout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_ready", start_ready, 1);
    rv_seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      rv_seen |= res_valid;
    end
    check("aborted_no_result", rv_seen, 0);
    do_op(tbl[2].a, tbl[2].b, tbl[2].cin, {tbl[2].cout, tbl[2].res});

    // Back-to-back with start_valid and res_ready both held high.
    base = n_acc;
    sb_q.push_back({1'b0, 256'd12});
    sb_q.push_back({1'b0, 256'd30});
    op_a = 256'd5;
    op_b = 256'd7;
    cin = 1'b0;
    start_valid = 1'b1;
    res_ready = 1'b1;
    n = 0;
    while (n_acc < base + 1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n_acc < base + 1) timeout("b2b_first_accept");
    op_a = 256'd10;
    op_b = 256'd20;
    n = 0;
    while (n_acc < base + 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    start_valid = 1'b0;
    if (n_acc < base + 2) timeout("b2b_second_accept");
    else check("b2b_gap", acc_gap, 1);
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    res_ready = 1'b0;
    if (sb_q.size() != 0) timeout("b2b_drain");

`ifdef MP_ADD_SEQ_SUB_EN
    sub_i = 1'b1;
    do_op('0, 256'd1, 1'b0, {1'b0, {N{1'b1}}});
    do_op(256'd9, 256'd4, 1'b0, {1'b1, 256'd5});
    sub_i = 1'b0;
    do_op(256'd9, 256'd4, 1'b0, {1'b0, 256'd13});
`endif

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
